// File: rtl/pulse_train_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_train_pkg;

    localparam int unsigned DEF_LEN_W = 8;
    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // A zero-length phase would collapse the waveform, so zero runs as one cycle.
    function automatic logic [31:0] eff_len(input logic [31:0] len);
        return (len == '0) ? 32'd1 : len;
    endfunction

endpackage

// File: rtl/pulse_train_generator_phase_counter.sv
// Loadable down-counter timing one HIGH or LOW phase; last flags the final cycle.
module phase_counter
    import pulse_train_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [LEN_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    assign last = (r_cnt == LEN_W'(1));

endmodule

// File: rtl/pulse_train_generator.sv
// Programmable pulse train: N pulses of H cycles high separated by L cycles low.
// Build option PULSE_TRAIN_CONTINUOUS_EN: count == 0 runs the train until abort/reset.
module pulse_train_generator
    import pulse_train_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] high_len,
    input  logic [LEN_W-1:0] low_len,
    input  logic [CNT_W-1:0] count,
    output logic             pulse,
    output logic             ready,
    output logic             done
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_pulse;
    logic             r_ready;
    logic             r_done;
    logic [LEN_W-1:0] r_high;
    logic [LEN_W-1:0] r_low;
    logic [CNT_W-1:0] r_remain;

    logic [LEN_W-1:0] w_high_in;
    logic [LEN_W-1:0] w_low_in;
    logic [LEN_W-1:0] w_ld_val;
    logic             w_ld;
    logic             w_dec;
    logic             w_en;
    logic             w_last;
    logic             w_more;
    logic             w_zero_fin;
    logic             w_accept;

    assign w_high_in = LEN_W'(eff_len(32'(high_len)));
    assign w_low_in  = LEN_W'(eff_len(32'(low_len)));
    assign w_accept  = start && r_ready;
    assign w_en      = (r_state == HIGH) || (r_state == LOW);

`ifdef PULSE_TRAIN_CONTINUOUS_EN
    logic r_cont;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cont <= 1'b0;
        end else if (w_accept) begin
            r_cont <= (count == '0);
        end
    end

    assign w_more     = r_cont || (r_remain > CNT_W'(1));
    assign w_zero_fin = 1'b0;
`else
    assign w_more     = (r_remain > CNT_W'(1));
    assign w_zero_fin = (count == '0);
`endif

    phase_counter #(
        .LEN_W (LEN_W)
    ) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_ld),
        .load_val (w_ld_val),
        .en       (w_en),
        .last     (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_val    = r_high;
        w_dec       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero_fin) begin
                        w_state_nxt = FIN;
                    end else begin
                        w_state_nxt = HIGH;
                        w_ld        = 1'b1;
                        w_ld_val    = w_high_in;
                    end
                end
            end
            HIGH: begin
                if (w_last) begin
                    if (w_more) begin
                        w_state_nxt = LOW;
                        w_ld        = 1'b1;
                        w_ld_val    = r_low;
                        w_dec       = 1'b1;
                    end else begin
                        w_state_nxt = FIN;
                    end
                end
            end
            LOW: begin
                if (w_last) begin
                    w_state_nxt = HIGH;
                    w_ld        = 1'b1;
                    w_ld_val    = r_high;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Abort overrides the phase sequencing; an idle FSM lets start win instead.
        if (abort && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
            w_ld        = 1'b0;
            w_dec       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_pulse  <= 1'b0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_high   <= '0;
            r_low    <= '0;
            r_remain <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pulse <= (w_state_nxt == HIGH);
            r_ready <= (w_state_nxt == IDLE);
            r_done  <= (w_state_nxt == FIN);
            if (w_accept) begin
                r_high   <= w_high_in;
                r_low    <= w_low_in;
                r_remain <= count;
            end else if (w_dec && (r_remain != '0)) begin
                r_remain <= r_remain - CNT_W'(1);
            end
        end
    end

    assign pulse = r_pulse;
    assign ready = r_ready;
    assign done  = r_done;

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed self-checking bench for pulse_train_generator (both macro builds).
module tb_pulse_train_generator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] high_len;
    logic [7:0] low_len;
    logic [7:0] count;
    logic       pulse;
    logic       ready;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_train_generator #(
        .LEN_W (8),
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .high_len (high_len),
        .low_len  (low_len),
        .count    (count),
        .pulse    (pulse),
        .ready    (ready),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int p, input int r, input int d);
        check({tag, ".pulse"}, int'(pulse), p);
        check({tag, ".ready"}, int'(ready), r);
        check({tag, ".done"},  int'(done),  d);
    endtask

    // Issues a start on the next edge (cycle t), then scrambles the inputs
    // so the train must come from captured values. Returns sampled at t+1.
    task automatic go(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l);
        count    = c;
        high_len = h;
        low_len  = l;
        start    = 1'b1;
        step();
        start    = 1'b0;
        count    = 8'd9;
        high_len = 8'd9;
        low_len  = 8'd9;
    endtask

    // Checks pulse for consecutive cycles starting at the current sample.
    task automatic check_pat(input string tag, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            check($sformatf("%s.p%0d", tag, i), int'(pulse), (pat[i] == "1") ? 1 : 0);
            check($sformatf("%s.d%0d", tag, i), int'(done), 0);
            step();
        end
    endtask

    initial begin
        int n_hi;
        int n_done;

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        high_len = '0; low_len = '0; count = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            outs("rst_hold", 0, 1, 0);
        end
        rst = 1'b1;
        step();
        outs("rst_rel", 0, 1, 0);

        // Single shortest pulse
        go(8'd1, 8'd1, 8'd1);
        outs("one_t1", 1, 0, 0);
        step();
        outs("one_t2", 0, 0, 1);
        step();
        outs("one_t3", 0, 1, 0);

        // Train N=3 H=2 L=3: busy t+1..t+13
        go(8'd3, 8'd2, 8'd3);
        check("train_rdy_t1", int'(ready), 0);
        check_pat("train", "110001100011");
        outs("train_t13", 0, 0, 1);
        step();
        outs("train_t14", 0, 1, 0);

        // Zero lengths behave as one
        go(8'd2, 8'd0, 8'd0);
        check_pat("zero", "101");
        outs("zero_t4", 0, 0, 1);
        step();
        outs("zero_t5", 0, 1, 0);

        // Start while busy ignored; abort on 2nd HIGH cycle
        go(8'd3, 8'd4, 8'd1);
        outs("busy_t1", 1, 0, 0);
        count = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        outs("busy_t2", 1, 0, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        outs("abort_t3", 0, 1, 0);
        step();
        outs("abort_t4", 0, 1, 0);
        step();
        outs("abort_t5", 0, 1, 0);

        // Start and abort together while idle: start wins
        abort = 1'b1;
        go(8'd1, 8'd2, 8'd1);
        abort = 1'b0;
        check_pat("st_ab", "11");
        outs("st_ab_done", 0, 0, 1);
        step();

        // Mid-train reset during LOW
        go(8'd3, 8'd1, 8'd3);
        outs("mrst_t1", 1, 0, 0);
        step();
        outs("mrst_t2", 0, 0, 0);
        rst = 1'b0;
        step();
        outs("mrst_t3", 0, 1, 0);
        rst = 1'b1;
        step();
        outs("mrst_t4", 0, 1, 0);
        step();
        outs("mrst_t5", 0, 1, 0);
        go(8'd2, 8'd1, 8'd2);
        check_pat("after_rst", "1001");
        outs("after_rst_done", 0, 0, 1);
        step();
        outs("after_rst_idle", 0, 1, 0);

        // Maximum high length
        go(8'd1, 8'd255, 8'd5);
        n_hi = 0;
        for (int i = 0; i < 255; i++) begin
            if (pulse) n_hi++;
            step();
        end
        check("maxh_cycles", n_hi, 255);
        outs("maxh_done", 0, 0, 1);
        step();

        // Maximum count
        go(8'd255, 8'd1, 8'd1);
        n_hi = 0; n_done = 0;
        for (int i = 0; i < 509; i++) begin
            if (pulse) n_hi++;
            if (done) n_done++;
            step();
        end
        check("maxc_pulses", n_hi, 255);
        check("maxc_early_done", n_done, 0);
        outs("maxc_done", 0, 0, 1);
        step();
        outs("maxc_idle", 0, 1, 0);

        // count == 0
`ifdef PULSE_TRAIN_CONTINUOUS_EN
        go(8'd0, 8'd1, 8'd1);
        n_hi = 0; n_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (pulse) n_hi++;
            if (done) n_done++;
            step();
        end
        check("cont_pulses", n_hi, 20);
        check("cont_done", n_done, 0);
        check("cont_busy", int'(ready), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        outs("cont_abort", 0, 1, 0);
        step();
        outs("cont_after", 0, 1, 0);
`else
        go(8'd0, 8'd3, 8'd3);
        outs("cnt0_t1", 0, 0, 1);
        step();
        outs("cnt0_t2", 0, 1, 0);
        step();
        outs("cnt0_t3", 0, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
